countdown_timer: RTL



---
 rtl/countdown_timer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with a prescaler. Times the random pre-stimulus
// delay of the reaction-time game: load a tick count, decrement it on
// every PRESCALE-th enabled clock, pulse Done once when it reaches zero,
// and keep Expired high until the timer is reloaded or cancelled.
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Enable,
    input  logic             Abort,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done,
    output logic             Expired
);

    // Prescaler is at least one bit wide even when PRESCALE == 1, in which
    // case it simply stays at zero and every enabled cycle is a tick.
    localparam int PW = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [PW-1:0]    r_pre;
    logic [PW-1:0]    w_pre_next;
    logic             r_busy;
    logic             r_done;
    logic             w_done_next;
    logic             r_expired;

    logic             w_pre_last;
    logic             w_load_zero;

    assign w_pre_last  = (r_pre == PRE_LAST);
    assign w_load_zero = (LoadValue == '0);

    // State and datapath registers; Reset has the highest priority.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pre     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_pre     <= w_pre_next;
            r_busy    <= (w_state_next == S_RUN);
            r_done    <= w_done_next;
            // Expired is the registered "in DONE" level, so a Load of zero
            // (which goes straight to DONE) also reports Expired.
            r_expired <= (w_state_next == S_DONE);
        end
    end

    // Next-state logic: Abort beats Load, Load beats the countdown.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_pre_next   = r_pre;
        w_done_next  = 1'b0;

        if (Abort) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
            w_pre_next   = '0;
        end else if (Load) begin
            w_count_next = LoadValue;
            w_pre_next   = '0;
            if (w_load_zero) begin
                w_state_next = S_DONE;
                w_done_next  = 1'b1;
            end else begin
                w_state_next = S_RUN;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (Enable) begin
                        if (w_pre_last) begin
                            w_pre_next   = '0;
                            w_count_next = r_count - WIDTH'(1);
                            // Count is never zero in RUN, so this cannot wrap.
                            if (r_count == WIDTH'(1)) begin
                                w_state_next = S_DONE;
                                w_done_next  = 1'b1;
                            end
                        end else begin
                            w_pre_next = r_pre + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_count_next = '0;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_count_next = '0;
                    w_pre_next   = '0;
                end
            endcase
        end
    end

    assign Count   = r_count;
    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Expired = r_expired;

endmodule
